// File: rtl/io_store_buffer.sv
// -----------------------------------------------------------------------------
// io_store_buffer
//
// Buffers IO store requests from the execute stage in a small FIFO and drains
// them one at a time onto the external IO bus with a valid/ready handshake.
// The core stalls only when the buffer is full. busy reports that stores are
// still buffered or in flight, so an IO store can be ordered before a later
// IO read.
//
// Ports:
//   clk       system clock, all state on the rising edge
//   rst_n     asynchronous active-low reset (drops any in-flight write)
//   st_valid  core presents a store request
//   st_addr   store IO address
//   st_data   store data
//   st_ready  buffer can accept a store this cycle
//   io_valid  bus write request valid (registered)
//   io_addr   bus write address (registered)
//   io_data   bus write data (registered)
//   io_ready  IO device accepts the current write
//   busy      any store buffered or in flight
//   count     number of entries held, including the in-flight one
//
// Build option:
//   IO_STORE_COALESCE_EN  when defined, a store to the same address as the
//                         newest entry overwrites that entry's data instead of
//                         allocating, unless that entry is already on the bus.
// -----------------------------------------------------------------------------
module io_store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       st_valid,
  input  logic [ADDR_W-1:0]          st_addr,
  input  logic [DATA_W-1:0]          st_data,
  output logic                       st_ready,
  output logic                       io_valid,
  output logic [ADDR_W-1:0]          io_addr,
  output logic [DATA_W-1:0]          io_data,
  input  logic                       io_ready,
  output logic                       busy,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic {IDLE, SEND} state_t;

  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];

  state_t            state_q, state_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              io_valid_q, io_valid_d;
  logic [ADDR_W-1:0] io_addr_q, io_addr_d;
  logic [DATA_W-1:0] io_data_q, io_data_d;

  logic              full;
  logic              coal_hit;
  logic              push;
  logic              push_alloc;
  logic              handshake;
  logic [PW-1:0]     rd_next;
  logic [PW-1:0]     wr_idx;
  logic [DATA_W-1:0] head_data;
  logic [DATA_W-1:0] next_data;

  assign full      = (count_q == CW'(DEPTH));
  assign rd_next   = rd_ptr_q + 1'b1;
  assign handshake = io_valid_q && io_ready;

`ifdef IO_STORE_COALESCE_EN
  logic [PW-1:0] newest_idx;
  assign newest_idx = wr_ptr_q - 1'b1;
  // The newest entry is the one on the bus only when it is the sole entry
  // and we are already sending it; in that case it must not change under us.
  assign coal_hit  = st_valid && (count_q != '0) &&
                     (mem_addr[newest_idx] == st_addr) &&
                     !((state_q == SEND) && (count_q == CW'(1)));
  assign st_ready  = !full || coal_hit;
  assign wr_idx    = coal_hit ? newest_idx : wr_ptr_q;
  // A coalescing write lands in the array at the same edge the entry may be
  // loaded onto the bus, so forward the new data into the load path.
  assign head_data = (coal_hit && (newest_idx == rd_ptr_q)) ? st_data : mem_data[rd_ptr_q];
  assign next_data = (coal_hit && (newest_idx == rd_next))  ? st_data : mem_data[rd_next];
`else
  assign coal_hit  = 1'b0;
  assign st_ready  = !full;
  assign wr_idx    = wr_ptr_q;
  assign head_data = mem_data[rd_ptr_q];
  assign next_data = mem_data[rd_next];
`endif

  assign push       = st_valid && st_ready;
  assign push_alloc = push && !coal_hit;

  // Storage array: no reset needed, validity is tracked by count/pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_idx] <= st_addr;
      mem_data[wr_idx] <= st_data;
    end
  end

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    io_valid_d = io_valid_q;
    io_addr_d  = io_addr_q;
    io_data_d  = io_data_q;

    if (push_alloc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (handshake)  rd_ptr_d = rd_next;

    // The head stays counted until its bus handshake completes.
    if (push_alloc && !handshake)      count_d = count_q + 1'b1;
    else if (!push_alloc && handshake) count_d = count_q - 1'b1;

    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          state_d    = SEND;
          io_valid_d = 1'b1;
          io_addr_d  = mem_addr[rd_ptr_q];
          io_data_d  = head_data;
        end
      end
      SEND: begin
        if (handshake) begin
          if (count_q > CW'(1)) begin
            io_addr_d = mem_addr[rd_next];
            io_data_d = next_data;
          end else if (push_alloc) begin
            // Buffer empties this edge but a new store arrives: pass it
            // straight through so the bus sees no gap.
            io_addr_d = st_addr;
            io_data_d = st_data;
          end else begin
            io_valid_d = 1'b0;
            state_d    = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      io_valid_q <= 1'b0;
      io_addr_q  <= '0;
      io_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      io_valid_q <= io_valid_d;
      io_addr_q  <= io_addr_d;
      io_data_q  <= io_data_d;
    end
  end

  assign io_valid = io_valid_q;
  assign io_addr  = io_addr_q;
  assign io_data  = io_data_q;
  assign count    = count_q;
  assign busy     = (count_q != '0);

endmodule
